t5_dec: RTL and testbench
=========================

// Module: t5_dec
// PURPOSE
//  Decode stage for the barrel-threaded RV32I pipeline. NHART harts are interleaved; the hart id rides in the low PC bits.
//  Sits between fetch and execute. Carries a 2-entry skid buffer with valid/ready on both sides, so fetch and execute
//  may stall independently. Supports per-hart flush and flags illegal encodings instead of dropping them.
// PARAMETERS
//  XLEN      32      datapath width
//  NHART     4       harts in the barrel; power of 2, 2..8
//  HW        $clog2(NHART)  hart-id width, derived, not overridable
//  RST_OPC   5'h0D   dopc value after reset (LUI = bubble)
// PORTS
//  sclk    in   1      clock, all flops rising edge
//  srst_n  in   1      asynchronous, active-low reset
//  fvld    in   1      fetch beat valid
//  frdy    out  1      decode can accept a beat
//  fpc     in   XLEN   beat PC; fpc[HW-1:0] = hart id
//  idat    in   32     instruction word
//  rs1a    out  5      RF read addr = idat[19:15], combinational
//  rs2a    out  5      RF read addr = idat[24:20], combinational
//  fhart   out  HW     fpc[HW-1:0], combinational, RF bank select
//  rs1d    in   XLEN   RF data for rs1a, same cycle
//  rs2d    in   XLEN   RF data for rs2a, same cycle
//  kflush  in   1      flush request from execute
//  khart   in   HW     hart being flushed
//  xrdy    in   1      execute accepts the output beat
//  dvld    out  1      output beat valid
//  dop1    out  XLEN   ALU operand 1
//  dop2    out  XLEN   ALU operand 2
//  dcp1    out  XLEN   compare/store operand: rs1d
//  dcp2    out  XLEN   compare/store operand: rs2d
//  dpc     out  XLEN   PC of the beat
//  dopc    out  5      idat[6:2]
//  dfn3    out  3      idat[14:12]
//  dfn7    out  7      idat[31:25]
//  drd     out  5      idat[11:7]
//  dhart   out  HW     hart of the beat
//  dill    out  1      illegal encoding
// BEHAVIOUR
//  Reset (async assert, sync deassert externally):
//   - dvld=0, frdy=1, both buffer entries invalid.
//   - dopc=RST_OPC; all other outputs 0.
//  Buffer:
//   - Entries are MAIN (drives outputs) and SKID. frdy is registered and equals !skid_valid.
//   - Accept = fvld&frdy. Operands are captured from rs1d/rs2d in the accept cycle; latency is 1 cycle.
//   - Output handshake: a beat leaves when dvld&xrdy.
//   - Accept with MAIN empty, or MAIN leaving and SKID empty -> beat goes to MAIN.
//   - Accept while MAIN is held (dvld&!xrdy) -> beat goes to SKID.
//   - MAIN leaves with SKID valid -> SKID moves to MAIN; a same-cycle accept cannot occur because frdy=0.
//   - Order is strictly preserved.
//  Flush, when kflush=1:
//   - Same cycle: invalidate MAIN and/or SKID entries whose hart==khart.
//   - An accepting beat with fpc[HW-1:0]==khart is dropped.
//   - Surviving entries compact: SKID survives and MAIN dies -> SKID moves to MAIN.
//   - The flush takes effect regardless of xrdy. A killed MAIN beat does not count as a handshake.
//  Operand selection:
//   - dop1 = fpc for AUIPC/JAL/BRANCH; 0 for LUI; rs1d otherwise.
//   - dop2 = rs2d for OP (01100); imm otherwise.
//  Immediates: I/S/B/U/J per RV32I, sign bit idat[31].
//  dill=1 when idat[1:0]!=2'b11, or when opc is not in:
//   - {00000,00011,00100,00101,01000,01100,01101,11000,11001,11011,11100}
//   - An illegal beat still flows with its fields decoded; execute raises the trap.
//  Hazards and forwarding are out of scope here.
// STRUCTURE
//  - t5_pkg: opcode localparams (OPC_LUI..OPC_SYSTEM), imm-format enum {FMT_I,FMT_S,FMT_B,FMT_U,FMT_J,FMT_R},
//    RST_OPC default.
//  - One sub-module, t5_imm: combinational format detect plus immediate generation (idat -> imm, fmt).
//    It is instantiated once on the input side.
//  - The top holds a packed beat struct, two entry registers with valid bits, and the control logic.
// TESTING
//  1. Reset: srst_n=0 mid-stream -> next cycle dvld=0, frdy=1, dopc=5'h0D, dop1=0.
//  2. Streaming: idat=32'h00500093 (addi x1,x0,5), rs1d=0, xrdy=1 -> next cycle dvld=1,
//     dop2=5, drd=1, dill=0; back-to-back beats at 1/cycle.
//  3. Stall: xrdy=0 for 3 cycles with fvld=1 -> second beat lands in SKID, frdy=0.
//     With xrdy=1 the beats emerge in order with no loss or duplication.
//  4. Flush: MAIN hart2, SKID hart1, kflush=1, khart=2 -> next cycle MAIN=hart1 beat, frdy=1;
//     an incoming hart2 beat in the same cycle is dropped.
//  5. Immediates: idat=32'hFE000EE3 (beq, offset -4), fpc=32'h100 -> dop1=32'h100, dop2=32'hFFFFFFFC.
//  6. Illegal: idat=32'h00000013 with idat[1:0] forced to 2'b01, and separately opc=5'b10101
//     -> dill=1, beat still delivered.

Source files
------------

// File: rtl/t5_pkg.sv
// t5_pkg: shared opcode constants, immediate formats and reset defaults
// for the barrel-threaded RV32I decode stage.
package t5_pkg;

    // RV32I major opcodes, idat[6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_MISC   = 5'b00011;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    // dopc after reset: LUI reads as a harmless bubble downstream
    localparam logic [4:0] RST_OPC = 5'h0D;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_R
    } fmt_t;

    // True for the major opcodes this core implements
    function automatic logic opc_legal(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_MISC, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
            OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: opc_legal = 1'b1;
            default:                                             opc_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/t5_imm.sv
// t5_imm: combinational format detect and sign-extended immediate
// generation for one RV32I instruction word. idat[1:0] carries no
// immediate information and is not needed here.
module t5_imm
    import t5_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:2]     idat,
    output logic [XLEN-1:0] imm,
    output fmt_t            fmt
);

    logic s;
    assign s = idat[31];

    // Pick the format from the opcode; unknown opcodes decode as I-type
    always_comb begin
        fmt = FMT_I;
        case (idat[6:2])
            OPC_STORE:            fmt = FMT_S;
            OPC_BRANCH:           fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:   fmt = FMT_U;
            OPC_JAL:              fmt = FMT_J;
            OPC_OP:               fmt = FMT_R;
            default:              fmt = FMT_I;
        endcase
    end

    // Assemble the immediate for the detected format
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I: imm = {{(XLEN-11){s}}, idat[30:20]};
            FMT_S: imm = {{(XLEN-11){s}}, idat[30:25], idat[11:7]};
            FMT_B: imm = {{(XLEN-12){s}}, idat[7], idat[30:25], idat[11:8], 1'b0};
            FMT_U: imm = {{(XLEN-31){s}}, idat[30:12], 12'b0};
            FMT_J: imm = {{(XLEN-20){s}}, idat[19:12], idat[20], idat[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/t5_dec.sv
// t5_dec: decode stage of the barrel-threaded RV32I pipeline.
// Handshake: on both sides a beat transfers on a rising edge where valid
// and ready are both high; valid never waits on ready, and a held beat
// keeps its payload stable until it transfers or is flushed.
// A two-entry buffer (MAIN drives the outputs, SKID absorbs one beat while
// MAIN is stalled) lets fetch and execute stall independently. frdy is
// the registered inverse of the SKID valid bit.
module t5_dec
    import t5_pkg::*;
#(
    parameter int         XLEN    = 32,
    parameter int         NHART   = 4,
    parameter logic [4:0] RST_OPC = t5_pkg::RST_OPC,
    localparam int        HW      = $clog2(NHART)
) (
    input  logic            sclk,
    input  logic            srst_n,
    input  logic            fvld,
    output logic            frdy,
    input  logic [XLEN-1:0] fpc,
    input  logic [31:0]     idat,
    output logic [4:0]      rs1a,
    output logic [4:0]      rs2a,
    output logic [HW-1:0]   fhart,
    input  logic [XLEN-1:0] rs1d,
    input  logic [XLEN-1:0] rs2d,
    input  logic            kflush,
    input  logic [HW-1:0]   khart,
    input  logic            xrdy,
    output logic            dvld,
    output logic [XLEN-1:0] dop1,
    output logic [XLEN-1:0] dop2,
    output logic [XLEN-1:0] dcp1,
    output logic [XLEN-1:0] dcp2,
    output logic [XLEN-1:0] dpc,
    output logic [4:0]      dopc,
    output logic [2:0]      dfn3,
    output logic [6:0]      dfn7,
    output logic [4:0]      drd,
    output logic [HW-1:0]   dhart,
    output logic            dill
);

    typedef struct packed {
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
        logic [XLEN-1:0] cp1;
        logic [XLEN-1:0] cp2;
        logic [XLEN-1:0] pc;
        logic [4:0]      opc;
        logic [2:0]      fn3;
        logic [6:0]      fn7;
        logic [4:0]      rd;
        logic [HW-1:0]   hart;
        logic            ill;
    } beat_t;

    beat_t           nb, mb, sb;
    logic            m_v, s_v;
    logic [XLEN-1:0] imm;
    fmt_t            fmt;
    logic            kill_m, kill_s, m_live, s_live, m_hold, acc;

    t5_imm #(.XLEN(XLEN)) u_imm (
        .idat (idat[31:2]),
        .imm  (imm),
        .fmt  (fmt)
    );

    assign rs1a  = idat[19:15];
    assign rs2a  = idat[24:20];
    assign fhart = fpc[HW-1:0];
    assign frdy  = ~s_v;

    // Build the decoded beat from the fetch side and same-cycle RF data
    always_comb begin
        nb      = '0;
        nb.op1  = rs1d;
        case (idat[6:2])
            OPC_AUIPC, OPC_JAL, OPC_BRANCH: nb.op1 = fpc;
            OPC_LUI:                        nb.op1 = '0;
            default:                        nb.op1 = rs1d;
        endcase
        nb.op2  = (fmt == FMT_R) ? rs2d : imm;
        nb.cp1  = rs1d;
        nb.cp2  = rs2d;
        nb.pc   = fpc;
        nb.opc  = idat[6:2];
        nb.fn3  = idat[14:12];
        nb.fn7  = idat[31:25];
        nb.rd   = idat[11:7];
        nb.hart = fpc[HW-1:0];
        nb.ill  = (idat[1:0] != 2'b11) | ~opc_legal(idat[6:2]);
    end

    // Flush kills and the resulting survive / hold / accept conditions
    always_comb begin
        kill_m = kflush & m_v & (mb.hart == khart);
        kill_s = kflush & s_v & (sb.hart == khart);
        m_live = m_v & ~kill_m;
        s_live = s_v & ~kill_s;
        m_hold = m_live & ~xrdy;
        acc    = fvld & frdy & ~(kflush & (fpc[HW-1:0] == khart));
    end

    // Buffer update: MAIN holds, refills from SKID, or takes the new beat
    always_ff @(posedge sclk or negedge srst_n) begin
        if (!srst_n) begin
            mb     <= '0;
            mb.opc <= RST_OPC;
            sb     <= '0;
            m_v    <= 1'b0;
            s_v    <= 1'b0;
        end else if (m_hold) begin
            s_v <= s_live | acc;
            if (!s_live && acc) begin
                sb <= nb;
            end
        end else if (s_live) begin
            mb  <= sb;
            m_v <= 1'b1;
            s_v <= 1'b0;
        end else if (acc) begin
            mb  <= nb;
            m_v <= 1'b1;
            s_v <= 1'b0;
        end else begin
            m_v <= 1'b0;
            s_v <= 1'b0;
        end
    end

    assign dvld  = m_v;
    assign dop1  = mb.op1;
    assign dop2  = mb.op2;
    assign dcp1  = mb.cp1;
    assign dcp2  = mb.cp2;
    assign dpc   = mb.pc;
    assign dopc  = mb.opc;
    assign dfn3  = mb.fn3;
    assign dfn7  = mb.fn7;
    assign drd   = mb.rd;
    assign dhart = mb.hart;
    assign dill  = mb.ill;

endmodule

// File: tb/tb_t5_dec.sv
// tb_t5_dec: table-driven directed bench for the t5_dec decode stage,
// plus hand-written stall, flush and reset sequences.
module tb_t5_dec;

    logic        sclk;
    logic        srst_n;
    logic        fvld;
    logic        frdy;
    logic [31:0] fpc;
    logic [31:0] idat;
    logic [4:0]  rs1a, rs2a;
    logic [1:0]  fhart;
    logic [31:0] rs1d, rs2d;
    logic        kflush;
    logic [1:0]  khart;
    logic        xrdy;
    logic        dvld;
    logic [31:0] dop1, dop2, dcp1, dcp2, dpc;
    logic [4:0]  dopc;
    logic [2:0]  dfn3;
    logic [6:0]  dfn7;
    logic [4:0]  drd;
    logic [1:0]  dhart;
    logic        dill;

    int n_cmp = 0;
    int n_err = 0;
    logic [4:0] exp_q[$];

    t5_dec dut (
        .sclk(sclk), .srst_n(srst_n), .fvld(fvld), .frdy(frdy), .fpc(fpc),
        .idat(idat), .rs1a(rs1a), .rs2a(rs2a), .fhart(fhart), .rs1d(rs1d),
        .rs2d(rs2d), .kflush(kflush), .khart(khart), .xrdy(xrdy), .dvld(dvld),
        .dop1(dop1), .dop2(dop2), .dcp1(dcp1), .dcp2(dcp2), .dpc(dpc),
        .dopc(dopc), .dfn3(dfn3), .dfn7(dfn7), .drd(drd), .dhart(dhart),
        .dill(dill)
    );

    // clock / reset
    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        logic [31:0] idat;
        logic [31:0] fpc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
        logic [4:0]  e_opc;
        logic [4:0]  e_rd;
        logic [2:0]  e_fn3;
        logic [6:0]  e_fn7;
        logic [1:0]  e_hart;
        logic        e_ill;
        logic        chk_op2;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fvld = 1'b1;
        idat = v.idat;
        fpc  = v.fpc;
        rs1d = v.rs1d;
        rs2d = v.rs2d;
    endtask

    task automatic drive_tag(input logic [31:0] pc, input logic [4:0] tag);
        fvld = 1'b1;
        fpc  = pc;
        idat = {20'h00000, tag, 7'b0010011};
        rs1d = 32'h0;
        rs2d = 32'h0;
    endtask

    task automatic chk_vec(input vec_t v, input int i);
        chk($sformatf("v%0d_dvld", i), 64'(dvld), 64'(1'b1));
        chk($sformatf("v%0d_op1", i), 64'(dop1), 64'(v.e_op1));
        if (v.chk_op2) chk($sformatf("v%0d_op2", i), 64'(dop2), 64'(v.e_op2));
        chk($sformatf("v%0d_cp1", i), 64'(dcp1), 64'(v.rs1d));
        chk($sformatf("v%0d_cp2", i), 64'(dcp2), 64'(v.rs2d));
        chk($sformatf("v%0d_pc", i), 64'(dpc), 64'(v.fpc));
        chk($sformatf("v%0d_opc", i), 64'(dopc), 64'(v.e_opc));
        chk($sformatf("v%0d_rd", i), 64'(drd), 64'(v.e_rd));
        chk($sformatf("v%0d_fn3", i), 64'(dfn3), 64'(v.e_fn3));
        chk($sformatf("v%0d_fn7", i), 64'(dfn7), 64'(v.e_fn7));
        chk($sformatf("v%0d_hart", i), 64'(dhart), 64'(v.e_hart));
        chk($sformatf("v%0d_ill", i), 64'(dill), 64'(v.e_ill));
        chk($sformatf("v%0d_frdy", i), 64'(frdy), 64'(1'b1));
    endtask

    initial begin
        logic take;
        //          idat          fpc        rs1d          rs2d          op1           op2           opc     rd      fn3   fn7    hart  ill c2
        vt[0]  = '{32'h00500093, 32'h10,  32'h0,       32'h77,      32'h0,       32'h5,        5'h04, 5'd1,  3'd0, 7'h00, 2'd0, 0, 1};
        vt[1]  = '{32'hFE000EE3, 32'h100, 32'h11,      32'h22,      32'h100,     32'hFFFFFFFC, 5'h18, 5'd29, 3'd0, 7'h7F, 2'd0, 0, 1};
        vt[2]  = '{32'h002081B3, 32'h21,  32'h7,       32'h9,       32'h7,       32'h9,        5'h0C, 5'd3,  3'd0, 7'h00, 2'd1, 0, 1};
        vt[3]  = '{32'h123452B7, 32'h32,  32'hAAAA,    32'hBB,      32'h0,       32'h12345000, 5'h0D, 5'd5,  3'd5, 7'h09, 2'd2, 0, 1};
        vt[4]  = '{32'h00001317, 32'h207, 32'h55,      32'hCC,      32'h207,     32'h1000,     5'h05, 5'd6,  3'd1, 7'h00, 2'd3, 0, 1};
        vt[5]  = '{32'hFF9FF0EF, 32'h301, 32'h66,      32'hDD,      32'h301,     32'hFFFFFFF8, 5'h1B, 5'd1,  3'd7, 7'h7F, 2'd1, 0, 1};
        vt[6]  = '{32'h0020A623, 32'h44,  32'h1000,    32'hDEAD,    32'h1000,    32'hC,        5'h08, 5'd12, 3'd2, 7'h00, 2'd0, 0, 1};
        vt[7]  = '{32'h00000011, 32'h55,  32'h5,       32'h1,       32'h5,       32'h0,        5'h04, 5'd0,  3'd0, 7'h00, 2'd1, 1, 1};
        vt[8]  = '{32'h00000057, 32'h66,  32'h9,       32'h2,       32'h9,       32'h0,        5'h15, 5'd0,  3'd0, 7'h00, 2'd2, 1, 0};
        vt[9]  = '{32'hFFF08113, 32'h77,  32'h40,      32'h3,       32'h40,      32'hFFFFFFFF, 5'h04, 5'd2,  3'd0, 7'h7F, 2'd3, 0, 1};
        vt[10] = '{32'h00408067, 32'h88,  32'h300,     32'h4,       32'h300,     32'h4,        5'h19, 5'd0,  3'd0, 7'h00, 2'd0, 0, 1};

        srst_n = 1'b0; fvld = 1'b0; fpc = '0; idat = '0; rs1d = '0; rs2d = '0;
        kflush = 1'b0; khart = '0; xrdy = 1'b1;
        repeat (2) @(negedge sclk);
        chk("rst_dvld", 64'(dvld), 64'(1'b0));
        chk("rst_frdy", 64'(frdy), 64'(1'b1));
        chk("rst_dopc", 64'(dopc), 64'(5'h0D));
        chk("rst_dop1", 64'(dop1), 64'(32'h0));
        chk("rst_dop2", 64'(dop2), 64'(32'h0));
        srst_n = 1'b1;
        @(negedge sclk);

        // back-to-back streaming through the vector table
        for (int i = 0; i < 11; i++) begin
            drive(vt[i]);
            #1;
            chk($sformatf("v%0d_rs1a", i), 64'(rs1a), 64'(vt[i].idat[19:15]));
            chk($sformatf("v%0d_rs2a", i), 64'(rs2a), 64'(vt[i].idat[24:20]));
            chk($sformatf("v%0d_fhart", i), 64'(fhart), 64'(vt[i].fpc[1:0]));
            @(negedge sclk);
            chk_vec(vt[i], i);
        end
        fvld = 1'b0;
        @(negedge sclk);
        chk("drain_dvld", 64'(dvld), 64'(1'b0));

        // stall: three held cycles, second beat parks in SKID
        xrdy = 1'b0;
        drive_tag(32'h400, 5'd1);
        @(negedge sclk);
        chk("stall_a_dvld", 64'(dvld), 64'(1'b1));
        chk("stall_a_frdy", 64'(frdy), 64'(1'b1));
        drive_tag(32'h404, 5'd2);
        @(negedge sclk);
        chk("stall_b_frdy", 64'(frdy), 64'(1'b0));
        drive_tag(32'h408, 5'd3);
        @(negedge sclk);
        chk("stall_hold_frdy", 64'(frdy), 64'(1'b0));
        chk("stall_hold_rd", 64'(drd), 64'(5'd1));
        xrdy = 1'b1;
        exp_q.push_back(5'd1);
        exp_q.push_back(5'd2);
        exp_q.push_back(5'd3);
        for (int cyc = 0; cyc < 8 && exp_q.size() > 0; cyc++) begin
            take = fvld & frdy;
            if (dvld) chk("stall_order", 64'(drd), 64'(exp_q.pop_front()));
            @(posedge sclk);
            #1;
            if (take) fvld = 1'b0;
            @(negedge sclk);
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL stall_timeout: got %0d beats left expected 0", exp_q.size());
        end
        chk("stall_nodup", 64'(dvld), 64'(1'b0));

        // flush: MAIN hart2, SKID hart1, flush hart2 with a hart2 beat offered
        xrdy = 1'b0;
        drive_tag(32'h102, 5'd10);
        @(negedge sclk);
        drive_tag(32'h101, 5'd11);
        @(negedge sclk);
        chk("fl_pre_frdy", 64'(frdy), 64'(1'b0));
        drive_tag(32'h10A, 5'd12);
        kflush = 1'b1; khart = 2'd2;
        @(negedge sclk);
        kflush = 1'b0; fvld = 1'b0;
        chk("fl_main_dvld", 64'(dvld), 64'(1'b1));
        chk("fl_main_rd", 64'(drd), 64'(5'd11));
        chk("fl_main_hart", 64'(dhart), 64'(2'd1));
        chk("fl_frdy", 64'(frdy), 64'(1'b1));
        xrdy = 1'b1;
        @(negedge sclk);
        chk("fl_drain", 64'(dvld), 64'(1'b0));
        drive_tag(32'h20E, 5'd13);
        kflush = 1'b1; khart = 2'd2;
        @(negedge sclk);
        chk("fl_drop_dvld", 64'(dvld), 64'(1'b0));
        chk("fl_drop_frdy", 64'(frdy), 64'(1'b1));
        drive_tag(32'h20F, 5'd14);
        @(negedge sclk);
        kflush = 1'b0; fvld = 1'b0;
        chk("fl_keep_dvld", 64'(dvld), 64'(1'b1));
        chk("fl_keep_hart", 64'(dhart), 64'(2'd3));
        chk("fl_keep_rd", 64'(drd), 64'(5'd14));

        // reset mid-stream
        drive(vt[3]);
        @(negedge sclk);
        srst_n = 1'b0;
        #1;
        chk("mrst_dvld", 64'(dvld), 64'(1'b0));
        @(negedge sclk);
        chk("mrst_dvld2", 64'(dvld), 64'(1'b0));
        chk("mrst_frdy", 64'(frdy), 64'(1'b1));
        chk("mrst_dopc", 64'(dopc), 64'(5'h0D));
        chk("mrst_dop1", 64'(dop1), 64'(32'h0));
        fvld = 1'b0;
        srst_n = 1'b1;
        @(negedge sclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
